// File: rtl/vga_pkg.sv
// Shared VGA types and default active-region constants (also used by the sync logic).
package vga_pkg;

    typedef enum logic [1:0] {
        PAT_BARS     = 2'd0,
        PAT_CHECKER  = 2'd1,
        PAT_GRADIENT = 2'd2,
        PAT_SOLID    = 2'd3
    } pattern_e;

    typedef logic [11:0] rgb_t;

    localparam logic [15:0] H_ACTIVE_START_D = 16'd144;
    localparam logic [15:0] H_ACTIVE_END_D   = 16'd784;
    localparam logic [15:0] V_ACTIVE_START_D = 16'd35;
    localparam logic [15:0] V_ACTIVE_END_D   = 16'd515;

    localparam logic [6:0]  BAR_LAST_SUB = 7'd79;

    // Bars run white..black, so the colour index counts down from 7.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        logic [2:0] c;
        c = 3'd7 - idx;
        return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
    endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Pixel-stream bundle: raw counters/syncs in, registered colour and delayed syncs out.
interface vga_pattern_gen_if;
    logic [15:0] h_count;
    logic [15:0] v_count;
    logic        hsync_in;
    logic        vsync_in;
    logic        hsync;
    logic        vsync;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;

    modport master (
        output h_count, v_count, hsync_in, vsync_in,
        input  hsync, vsync, red, green, blue
    );

    modport slave (
        input  h_count, v_count, hsync_in, vsync_in,
        output hsync, vsync, red, green, blue
    );
endinterface

// File: rtl/vga_frame_sequencer.sv
// Frame tick detection, frame counter and pattern-select FSM.
// Optional dwell-based auto-advance enabled by VGA_PAT_AUTO_ADVANCE_EN.
module vga_frame_sequencer
    import vga_pkg::*;
#(
    parameter int unsigned FRAMES_PER_PATTERN = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_vsync,
    input  logic       i_next_pattern,
    output pattern_e   o_pattern,
    output logic [7:0] o_frame_count
);

    pattern_e   r_state;
    pattern_e   w_state_next;
    logic       r_vs_prev;
    logic       r_pend;
    logic [7:0] r_frame;
    logic       w_tick;
    logic       w_auto;
    logic       w_adv;

    assign w_tick = i_vsync && !r_vs_prev;

`ifdef VGA_PAT_AUTO_ADVANCE_EN
    localparam int unsigned DW = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
    logic [DW-1:0] r_dwell;

    assign w_auto = w_tick && (r_dwell == DW'(FRAMES_PER_PATTERN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_dwell <= '0;
        else if (w_auto)
            r_dwell <= '0;
        else if (w_tick)
            r_dwell <= r_dwell + 1'b1;
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (FRAMES_PER_PATTERN != 0);
    assign w_auto       = 1'b0;
`endif

    // A request pulse coincident with the tick is honoured at that tick.
    assign w_adv = w_tick && (r_pend || i_next_pattern || w_auto);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= PAT_BARS;
            r_vs_prev <= 1'b0;
            r_pend    <= 1'b0;
            r_frame   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_vs_prev <= i_vsync;
            r_pend    <= w_tick ? 1'b0 : (r_pend || i_next_pattern);
            if (w_tick)
                r_frame <= r_frame + 8'd1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_adv) begin
            case (r_state)
                PAT_BARS:     w_state_next = PAT_CHECKER;
                PAT_CHECKER:  w_state_next = PAT_GRADIENT;
                PAT_GRADIENT: w_state_next = PAT_SOLID;
                PAT_SOLID:    w_state_next = PAT_BARS;
            endcase
        end
    end

    assign o_pattern     = r_state;
    assign o_frame_count = r_frame;

endmodule

// File: rtl/vga_pattern_gen.sv
// Two-stage pixel pipeline producing test-pattern RGB with syncs at matching latency.
// Auto-advance of patterns is enabled by defining VGA_PAT_AUTO_ADVANCE_EN.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter logic [15:0] H_ACTIVE_START     = H_ACTIVE_START_D,
    parameter logic [15:0] H_ACTIVE_END       = H_ACTIVE_END_D,
    parameter logic [15:0] V_ACTIVE_START     = V_ACTIVE_START_D,
    parameter logic [15:0] V_ACTIVE_END       = V_ACTIVE_END_D,
    parameter rgb_t        SOLID_RGB          = 12'hFFF,
    parameter int unsigned FRAMES_PER_PATTERN = 60
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_pattern_gen_if.slave   px,
    input  logic               next_pattern,
    output logic [1:0]         pattern,
    output logic [7:0]         frame_count
);

    pattern_e   w_pattern;
    logic       w_active;
    logic       r_active;
    logic [9:0] r_x;
    logic [8:0] r_y;
    logic       r_hs1;
    logic       r_vs1;
    logic [6:0] r_sub;
    logic [2:0] r_bar;
    rgb_t       w_rgb;
    logic       w_unused;

    vga_frame_sequencer #(
        .FRAMES_PER_PATTERN(FRAMES_PER_PATTERN)
    ) u_seq (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_vsync        (px.vsync_in),
        .i_next_pattern (next_pattern),
        .o_pattern      (w_pattern),
        .o_frame_count  (frame_count)
    );

    assign pattern  = w_pattern;
    assign w_active = (px.h_count >= H_ACTIVE_START) && (px.h_count < H_ACTIVE_END) &&
                      (px.v_count >= V_ACTIVE_START) && (px.v_count < V_ACTIVE_END);

    // Bar index tracks x/80 with a wrap-at-79 sub-counter realigned at each line start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_hs1    <= 1'b0;
            r_vs1    <= 1'b0;
            r_sub    <= '0;
            r_bar    <= '0;
        end else begin
            r_active <= w_active;
            r_x      <= 10'(px.h_count - H_ACTIVE_START);
            r_y      <= 9'(px.v_count - V_ACTIVE_START);
            r_hs1    <= px.hsync_in;
            r_vs1    <= px.vsync_in;
            if (px.h_count == H_ACTIVE_START) begin
                r_sub <= '0;
                r_bar <= '0;
            end else if (r_sub == BAR_LAST_SUB) begin
                r_sub <= '0;
                r_bar <= r_bar + 3'd1;
            end else begin
                r_sub <= r_sub + 7'd1;
            end
        end
    end

    always_comb begin
        w_rgb = '0;
        if (r_active) begin
            case (w_pattern)
                PAT_BARS:     w_rgb = bar_colour(r_bar);
                PAT_CHECKER:  w_rgb = (r_x[5] ^ r_y[5]) ? 12'hFFF : 12'h000;
                PAT_GRADIENT: w_rgb = {r_x[9:6], r_y[8:5], frame_count[5:2]};
                PAT_SOLID:    w_rgb = SOLID_RGB;
            endcase
        end
    end

    assign w_unused = ^{r_x[4:0], r_y[4:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px.red   <= '0;
            px.green <= '0;
            px.blue  <= '0;
            px.hsync <= 1'b0;
            px.vsync <= 1'b0;
        end else begin
            px.red   <= w_rgb[11:8];
            px.green <= w_rgb[7:4];
            px.blue  <= w_rgb[3:0];
            px.hsync <= r_hs1;
            px.vsync <= r_vs1;
        end
    end

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Pixel-colour stage of the VGA controller: sits directly downstream of the horizontal/vertical counters and replaces the fixed white-fill colour logic. Consumes the raw counter values and sync pulses, and produces registered 4:4:4 RGB together with sync delayed to the same latency. It holds four selectable test patterns, changed at frame boundaries only.

## Interface
- `H_ACTIVE_START`, 144: first visible horizontal count.
- `H_ACTIVE_END`, 784: first non-visible horizontal count after the active region (exclusive).
- `V_ACTIVE_START`, 35: first visible line.
- `V_ACTIVE_END`, 515: exclusive end of the visible lines (480 lines).
- `SOLID_RGB`, 12'hFFF: colour for SOLID, {R,G,B}.
- `FRAMES_PER_PATTERN`, 60: dwell in frames for auto-advance.
- `clk` in 1: pixel clock (25 MHz domain). This is the block's single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `h_count` in 16: horizontal counter value.
- `v_count` in 16: vertical counter value.
- `hsync_in` in 1: active-high horizontal sync from the timing logic.
- `vsync_in` in 1: active-high vertical sync from the timing logic.
- `next_pattern` in 1: single-cycle request to advance the pattern.
- `hsync` out 1: `hsync_in` delayed 2 cycles.
- `vsync` out 1: `vsync_in` delayed 2 cycles.
- `red` out 4, `green` out 4, `blue` out 4: pixel colour.
- `pattern` out 2: current pattern (0 BARS, 1 CHECKER, 2 GRADIENT, 3 SOLID).
- `frame_count` out 8: free-running frame counter.

## Operation
- **Stage 1** (registered):
  - active = `H_ACTIVE_START` ≤ h < `H_ACTIVE_END` && `V_ACTIVE_START` ≤ v < `V_ACTIVE_END`.
  - x = h − `H_ACTIVE_START` (10 b); y = v − `V_ACTIVE_START` (9 b).
  - Capture the syncs.
- **Bar index** = floor(x/80), range 0..7. It is produced by a 0..79 sub-counter plus a 3-bit index; there is no divider. Both reset when h == `H_ACTIVE_START`.
- **Stage 2** (registered) computes the colour. Outside the active region, RGB = 0.
  - BARS: c = 7 − bar_idx; R = c[2] ? F : 0, G = c[1] ? F : 0, B = c[0] ? F : 0.
  - CHECKER: all channels = (x[5] ^ y[5]) ? F : 0.
  - GRADIENT: R = x[9:6], G = y[8:5], B = frame_count[5:2].
  - SOLID: `SOLID_RGB`.
- **Frame tick**: a 0→1 edge of `vsync_in`, detected against its previous registered value. `frame_count` increments on each tick and wraps 255→0.
- **Manual advance**:
  - A `next_pattern` pulse sets a pending flag.
  - At the next tick, `pattern` ← `pattern` + 1 (wraps 3→0) and the flag clears.
  - Multiple pulses before one tick cause a single advance.
  - A pulse in the same cycle as a tick is applied at that tick.
- **Pattern-select FSM**: states are the four patterns. The only transition is +1 at a tick with an advance request; there are no other transitions.
- **Reset** (asynchronous, any time, including mid-line): all outputs 0, `pattern` = BARS, `frame_count` = 0, pending flag and dwell counter cleared, pipeline flushed.

## Timing
- Latency from `h_count`/`v_count`/`*sync_in` to RGB and syncs is exactly 2 cycles, and is identical for all outputs.
- `pattern` updates 1 cycle after the tick cycle.
- The colour uses the new pattern from the first pixel whose stage-2 evaluation follows that update. Because the vsync pulse lies in vertical blanking, no visible tearing occurs.
- `frame_count` updates 1 cycle after the tick cycle.

## Configuration
- `VGA_PAT_AUTO_ADVANCE_EN` defined:
  - A dwell counter (0..`FRAMES_PER_PATTERN`−1) increments per tick.
  - When the dwell counter is at its maximum, the tick also advances the pattern and clears the counter.
  - If a manual request and an auto request coincide at the same tick, the pattern advances by one only, and the dwell counter clears.
- Undefined: there is no dwell counter, and only `next_pattern` advances the pattern.

## Structure
- **Shared package `vga_pkg`**:
  - Pattern enum (`PAT_BARS`..`PAT_SOLID`).
  - 12-bit RGB typedef.
  - Default active-region constants (144/784/35/515), shared with the sync logic.
- **Sub-module `vga_frame_sequencer`**:
  - Contains tick detection, `frame_count`, the pending flag, the dwell counter and the pattern FSM.
  - Outputs `pattern` and `frame_count`.
- The top module holds the two-stage pixel pipeline.

## Test plan
1. **Reset**: hold `rst_n` low while counts sweep. RGB, `hsync`, `vsync`, `pattern` and `frame_count` must all be 0. Release reset; the first valid output appears 2 cycles after the inputs.
2. **BARS**: drive v = 100 with h = 144, 224 and 783. After 2 cycles, RGB must be FFF, then FF0, then 000.
3. **Blanking and sync alignment**: drive h = 100, v = 100, then h = 300, v = 20. RGB must be 0 in both cases. `hsync` must equal `hsync_in` delayed exactly 2 cycles.
4. **Deferred manual advance**: pulse `next_pattern` at v = 200. `pattern` must stay 0 until the next `vsync_in` rising edge, then become 1. Then drive CHECKER with x = 32, y = 0 (h = 176, v = 35); RGB must be FFF.
5. **Advance edge cases**:
   - Two pulses within one frame produce a single advance.
   - Four advances wrap `pattern` back to 0.
   - A pulse coincident with the tick advances at that tick.
6. **Auto-advance**: with `VGA_PAT_AUTO_ADVANCE_EN` defined and `FRAMES_PER_PATTERN` = 2, the pattern sequence is 0,0,1,1,2,2,3,3,0 on successive ticks. A manual pulse coincident with an auto-advance tick still advances by one only.
